// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding, the bubble
// instruction and the opcode/funct values shared with the ID-stage decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS      = 2'd1,
    MISS_KILL = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 encodes as all zeros, so a bubble is a real nop
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;

  // Sign-extended, word-scaled branch displacement
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-cache read port between the fetch stage and the I-cache.
interface if_stage_if;
  logic        ren;
  logic [29:0] addr;
  logic        stall;
  logic [31:0] rdata;

  modport master (output ren, output addr, input stall, input rdata);
  modport slave  (input ren, input addr, output stall, output rdata);
endinterface

// File: rtl/if_stage_npc_sel.sv
// Next-PC selection: picks the redirect target from the ID-stage controls,
// otherwise the sequential PC+4. Redirect is raw here; the stall gating
// happens in the fetch stage.
module npc_sel
  import cpu_pkg::*;
(
  input  logic        pc_src,
  input  logic        jump,
  input  logic        jump_r,
  input  logic [31:0] pc,
  input  logic [31:0] ifid_inst,
  input  logic [31:0] ifid_pc4,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        redirect
);

  // Opcode bits are decoded elsewhere; only the immediate/index fields matter here
  logic unused_opcode;
  assign unused_opcode = ^ifid_inst[31:26];

  // Priority select: jr/jalr over j/jal over taken branch over sequential
  always_comb begin
    next_pc  = pc + 32'd4;
    redirect = 1'b0;
    if (jump_r) begin
      next_pc  = rs_data;
      redirect = 1'b1;
    end else if (jump) begin
      next_pc  = {ifid_pc4[31:28], ifid_inst[25:0], 2'b00};
      redirect = 1'b1;
    end else if (pc_src) begin
      next_pc  = ifid_pc4 + branch_offset(ifid_inst[15:0]);
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, I-cache request, IF/ID register and the
// miss FSM that parks a redirect target while a miss is outstanding.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic        IF_Flush,
  input  logic        Jump,
  input  logic        JumpR,
  input  logic [31:0] rs_data,
  input  logic        hazard_stall,
  if_stage_if.master  icache,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_stall
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  pend_pc, pend_nxt;
  logic         ren;
  logic [31:0]  inst_q, inst_nxt;
  logic [31:0]  pc4_q, pc4_nxt;
  logic         valid_q, valid_nxt;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         take_redirect;

  npc_sel u_npc_sel (
    .pc_src    (PCSrc),
    .jump      (Jump),
    .jump_r    (JumpR),
    .pc        (pc),
    .ifid_inst (inst_q),
    .ifid_pc4  (pc4_q),
    .rs_data   (rs_data),
    .next_pc   (next_pc),
    .redirect  (redirect)
  );

  assign take_redirect = redirect & ~hazard_stall;
  assign fetch_stall   = icache.stall & ren;
  assign icache.ren    = ren;
  assign icache.addr   = pc[31:2];
  assign ifid_inst     = inst_q;
  assign ifid_pc4      = pc4_q;
  assign ifid_valid    = valid_q;

  // State register, PC, parked target and IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      pend_pc <= '0;
      ren     <= 1'b0;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_nxt;
      ren     <= 1'b1;
      inst_q  <= inst_nxt;
      pc4_q   <= pc4_nxt;
      valid_q <= valid_nxt;
    end
  end

  // Next-state, PC and IF/ID update; hazard_stall freezes everything
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_pc;
    inst_nxt  = inst_q;
    pc4_nxt   = pc4_q;
    valid_nxt = valid_q;
    if (!hazard_stall) begin
      // Anything that does not accept rdata below leaves a bubble
      inst_nxt  = NOP_INST;
      valid_nxt = 1'b0;
      if (ren) begin
        case (state)
          RUN, MISS: begin
            if (icache.stall) begin
              if (take_redirect) begin
                pend_nxt  = next_pc;
                state_nxt = MISS_KILL;
              end else begin
                state_nxt = MISS;
              end
            end else begin
              pc_nxt    = next_pc;
              state_nxt = RUN;
              if (!IF_Flush && !take_redirect) begin
                inst_nxt  = icache.rdata;
                pc4_nxt   = pc + 32'd4;
                valid_nxt = 1'b1;
              end
            end
          end
          MISS_KILL: begin
            if (icache.stall) begin
              if (take_redirect) pend_nxt = next_pc;
            end else begin
              // A fresh redirect is newer than the parked one
              pc_nxt    = take_redirect ? next_pc : pend_pc;
              state_nxt = RUN;
            end
          end
          default: state_nxt = RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step drives the ID controls and cache
// stall for one cycle and queues the hand-computed post-edge outputs; a
// separate monitor pops and compares at the following falling edge.
module tb_if_stage;

  typedef struct packed {
    logic        ren;
    logic [29:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src, if_flush, jump, jump_r, hazard_stall;
  logic [31:0] rs_data;
  logic        cache_stall;
  logic [31:0] ifid_inst, ifid_pc4;
  logic        ifid_valid, fetch_stall;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_ren_prev = 1'b0;

  if_stage_if icache ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCSrc        (pc_src),
    .IF_Flush     (if_flush),
    .Jump         (jump),
    .JumpR        (jump_r),
    .rs_data      (rs_data),
    .hazard_stall (hazard_stall),
    .icache       (icache),
    .ifid_inst    (ifid_inst),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .fetch_stall  (fetch_stall)
  );

  always #5 clk = ~clk;

  // Instruction memory image
  function automatic logic [31:0] mem_word(input logic [29:0] w);
    case (w)
      30'h0000_0004: mem_word = 32'h1000_0003; // beq imm=3 at 0x10
      30'h0000_0008: mem_word = 32'h0060_0008; // jr at 0x20
      30'h0000_000B: mem_word = 32'h1000_0014; // beq imm=0x14 at 0x2C
      30'h0000_0011: mem_word = 32'h0060_0008; // jr at 0x44
      30'h0400_0001: mem_word = 32'h0800_0040; // j 0x40 at 0x1000_0004
      30'h0400_0040: mem_word = 32'h0060_0008; // jr at 0x1000_0100
      default:       mem_word = {2'b10, w};
    endcase
  endfunction

  assign icache.stall = cache_stall;
  always_comb icache.rdata = mem_word(icache.addr);

  // Monitor: compare registered outputs against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {icache.ren, icache.addr, ifid_valid, ifid_inst, ifid_pc4};
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL fetch_out t=%0t: got ren=%b addr=%h valid=%b inst=%h pc4=%h, want ren=%b addr=%h valid=%b inst=%h pc4=%h",
                 $time, got.ren, got.addr, got.valid, got.inst, got.pc4,
                 e.ren, e.addr, e.valid, e.inst, e.pc4);
      end
    end
  end

  task automatic step(input logic r, hz, ps, fl, jp, jr,
                      input logic [31:0] rs, input logic st,
                      input logic e_ren, input logic [29:0] e_addr,
                      input logic e_valid, input logic [31:0] e_inst,
                      input logic [31:0] e_pc4);
    exp_t e;
    logic want_fs;
    rst = r; hazard_stall = hz; pc_src = ps; if_flush = fl;
    jump = jp; jump_r = jr; rs_data = rs; cache_stall = st;
    #1;
    want_fs = st & exp_ren_prev;
    n_vec++;
    if (fetch_stall !== want_fs) begin
      n_bad++;
      $display("FAIL fetch_stall t=%0t: got %b want %b", $time, fetch_stall, want_fs);
    end
    @(posedge clk);
    e = {e_ren, e_addr, e_valid, e_inst, e_pc4};
    sb.push_back(e);
    exp_ren_prev = e_ren;
    #1;
  endtask

  initial begin
    rst = 1'b1; hazard_stall = 1'b0; pc_src = 1'b0; if_flush = 1'b0;
    jump = 1'b0; jump_r = 1'b0; rs_data = '0; cache_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //    rst hz ps fl jp jr rs            st   ren addr          v  inst          pc4
    step(1, 0, 0, 0, 0, 0, 32'h0,        0,   0, 30'h0,        0, 32'h0,        32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h0,        0, 32'h0,        32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h1,        1, 32'h8000_0000, 32'h4);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h2,        1, 32'h8000_0001, 32'h8);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h3,        1, 32'h8000_0002, 32'hC);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h4,        1, 32'h8000_0003, 32'h10);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h5,        1, 32'h1000_0003, 32'h14);
    // taken beq: fetch at 0x14 squashed, target 0x20
    step(0, 0, 1, 1, 0, 0, 32'h0,        0,   1, 30'h8,        0, 32'h0,        32'h14);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h9,        1, 32'h0060_0008, 32'h24);
    step(0, 0, 0, 1, 0, 1, 32'h1000_0004, 0,  1, 30'h0400_0001, 0, 32'h0,        32'h24);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h0400_0002, 1, 32'h0800_0040, 32'h1000_0008);
    // hazard stall with Jump in the first cycle: nothing moves
    step(0, 1, 0, 1, 1, 0, 32'h0,        0,   1, 30'h0400_0002, 1, 32'h0800_0040, 32'h1000_0008);
    step(0, 1, 0, 0, 0, 0, 32'h0,        0,   1, 30'h0400_0002, 1, 32'h0800_0040, 32'h1000_0008);
    // jump re-presented: target 0x1000_0100
    step(0, 0, 0, 1, 1, 0, 32'h0,        0,   1, 30'h0400_0040, 0, 32'h0,        32'h1000_0008);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h0400_0041, 1, 32'h0060_0008, 32'h1000_0104);
    // jr to 0x44
    step(0, 0, 0, 1, 0, 1, 32'h44,       0,   1, 30'h11,       0, 32'h0,        32'h1000_0104);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h12,       1, 32'h0060_0008, 32'h48);
    step(0, 0, 0, 1, 0, 1, 32'h2C,       0,   1, 30'hB,        0, 32'h0,        32'h48);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'hC,        1, 32'h1000_0014, 32'h30);
    // miss at 0x30 with beq to 0x80 in the first miss cycle
    step(0, 0, 1, 1, 0, 0, 32'h0,        1,   1, 30'hC,        0, 32'h0,        32'h30);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 0, 32'h0,      1,   1, 30'hC,        0, 32'h0,        32'h30);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h20,       0, 32'h0,        32'h30);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h21,       1, 32'h8000_0020, 32'h84);
    // miss at 0x84, redirect parked, then reset on the third miss cycle
    step(0, 0, 0, 0, 0, 0, 32'h0,        1,   1, 30'h21,       0, 32'h0,        32'h84);
    step(0, 0, 0, 1, 0, 1, 32'h200,      1,   1, 30'h21,       0, 32'h0,        32'h84);
    step(1, 0, 0, 0, 0, 0, 32'h0,        1,   0, 30'h0,        0, 32'h0,        32'h0);
    // ren low: a stray stall must not show on fetch_stall
    step(0, 0, 0, 0, 0, 0, 32'h0,        1,   1, 30'h0,        0, 32'h0,        32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h1,        1, 32'h8000_0000, 32'h4);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h2,        1, 32'h8000_0001, 32'h8);
    // plain miss then hit: data accepted from MISS
    step(0, 0, 0, 0, 0, 0, 32'h0,        1,   1, 30'h2,        0, 32'h0,        32'h8);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h3,        1, 32'h8000_0002, 32'hC);
    // redirect to the current PC (0xC)
    step(0, 0, 0, 1, 0, 1, 32'hC,        0,   1, 30'h3,        0, 32'h0,        32'hC);
    step(0, 0, 0, 0, 0, 0, 32'h0,        0,   1, 30'h4,        1, 32'h8000_0003, 32'h10);
    repeat (2) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-cache read port, and holds the IF/ID pipeline register. It consumes the redirect and flush controls that the ID-stage control decoder produces from the IF/ID instruction: PCSrc, IF_Flush, Jump and JumpR. It computes branch and jump targets from its own IF/ID contents, and absorbs I-cache misses, including a redirect that arrives while a miss is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PCSrc  in  1  branch taken (beq with eq=1).
- IF_Flush  in  1  squash the instruction currently being fetched.
- Jump  in  1  j/jal redirect.
- JumpR  in  1  jr/jalr redirect.
- rs_data  in  32  forwarded rs value; jr/jalr target.
- hazard_stall  in  1  load-use stall; freezes PC and IF/ID.
- ICACHE_ren  out  1  I-cache read request; registered.
- ICACHE_addr  out  30  word address, equal to PC[31:2].
- ICACHE_stall  in  1  cache miss; asserted combinationally in the request cycle.
- ICACHE_rdata  in  32  instruction; valid in any cycle with ren=1 and stall=0.
- ifid_inst  out  32  IF/ID instruction; bubble value is 32'h0 (sll nop).
- ifid_pc4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_stall  out  1  combinational; equals ICACHE_stall & ICACHE_ren.

## Operation
- Next-PC priority: JumpR, then Jump, then PCSrc, then PC+4.
  - JumpR target: rs_data.
  - Jump target: {ifid_pc4[31:28], ifid_inst[25:0], 2'b00}.
  - PCSrc target: ifid_pc4 + {{14{ifid_inst[15]}}, ifid_inst[15:0], 2'b00}, modulo 2^32.
- Redirect: any of JumpR, Jump or PCSrc high while hazard_stall=0. The decoder always asserts IF_Flush together with a redirect. IF_Flush alone writes a bubble only.
- hazard_stall has top priority. PC, IF/ID and the FSM state hold, and any redirect or flush that cycle is ignored (the ID instruction re-presents it).
- IF/ID update when not held:
  - flush, or the fetch is stalled or killed: write a bubble (inst 0, valid 0, ifid_pc4 unchanged);
  - otherwise: write {ICACHE_rdata, PC+4, 1}.
- FSM states: RUN, MISS, MISS_KILL. Reset state is RUN.
  - RUN, ICACHE_stall=0: PC <= next PC.
  - RUN, ICACHE_stall=1: PC holds. Go to MISS, or to MISS_KILL if a redirect occurs in the same cycle (latch pend_pc <= target).
  - MISS, stall=1: hold. A redirect latches pend_pc and moves to MISS_KILL.
  - MISS, stall=0: rdata is accepted as in RUN (including any same-cycle redirect); go to RUN.
  - MISS_KILL, stall=1: hold. A later redirect overwrites pend_pc.
  - MISS_KILL, stall=0: discard rdata, write a bubble, PC <= pend_pc; go to RUN.
- ICACHE_addr is stable for the whole miss; the PC never changes while ICACHE_stall=1.

## Timing
- Reset values: PC=RESET_PC, ICACHE_ren=0, ifid_inst=0, ifid_pc4=0, ifid_valid=0, state=RUN, pend_pc=0.
- ICACHE_ren rises in the first cycle after rst falls and stays 1. fetch_stall is 0 while ren=0.
- A cache hit reaches IF/ID one edge after the request (latency 1).
- Taken branch or jump: exactly one bubble (the squashed PC+4 fetch). The target fetch is issued in the next cycle.
- rst asserted mid-miss: everything returns to reset values on that edge and pend_pc is cleared. The cache sees ren=0 for at least one cycle.
- Redirect to a target equal to the current PC is legal and behaves like any other redirect.

## Structure
- Shared package cpu_pkg holds:
  - the fetch-state enum (RUN/MISS/MISS_KILL);
  - NOP_INST=32'h0;
  - opcode constants shared with the control decoder.
- One combinational sub-module, npc_sel: inputs are the control bits, PC, ifid_inst, ifid_pc4 and rs_data; outputs are next_pc and redirect.
- The FSM, PC, pend_pc and IF/ID register stay in if_stage.

## Test plan
- Reset, then hits on 4 sequential words at RESET_PC=0: addr 0,1,2,3; ifid_pc4 4,8,12,16; ifid_valid=1 from the second cycle after reset.
- beq at PC 0x10 with imm=3, PCSrc+IF_Flush for one cycle: one bubble, next fetch addr = 0x20>>2; the instruction fetched at 0x14 never becomes valid.
- j with index 0x40 at ifid_pc4=0x1000_0008: next PC = 0x1000_0100. jr with rs_data=0x44: next PC = 0x44.
- hazard_stall held for 2 cycles with Jump high in the first: PC, IF/ID unchanged for both; the jump takes effect only once hazard_stall drops.
- Miss at PC 0x30 (stall for 5 cycles) with PCSrc to 0x80 in the first miss cycle: addr held at 0xC, 5 bubbles, then one more bubble and fetch at addr 0x20, no instruction from 0x30 is ever valid.
- rst pulsed during the third miss cycle: PC=0, ren=0 for one cycle, then a clean restart.
